// File: rtl/btb_predictor_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and constants for the parametrised BTB
//               predictor: default word size, FSM state encoding and
//               direction-counter encodings derived from CTR_BITS.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int BP_WORD_SIZE = 16;

    // INIT sweeps the table clear; READY is normal prediction/update.
    typedef enum logic [0:0] {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_t;

    // Weakly not-taken: the largest value whose MSB is still clear.
    function automatic int unsigned CTR_WEAK_NT(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

    // Weakly taken: the smallest value whose MSB is set.
    function automatic int unsigned CTR_WEAK_T(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_predictor_param_if.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor_param_if
// Description : Fetch-lookup and branch-resolution bundle between the
//               pipeline (master) and the BTB predictor (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface btb_predictor_param_if
    import bp_pkg::*;
#(
    parameter int WORD_SIZE  = BP_WORD_SIZE,
    parameter int INDEX_BITS = 8
);
    logic [WORD_SIZE-1:0]  fetch_pc;
    logic                  pred_taken;
    logic [WORD_SIZE-1:0]  pred_pc;
    logic [INDEX_BITS-1:0] pred_hist;
    logic                  upd_valid;
    logic [WORD_SIZE-1:0]  upd_pc;
    logic [INDEX_BITS-1:0] upd_hist;
    logic                  upd_taken;
    logic [WORD_SIZE-1:0]  upd_target;
    logic                  upd_mispredict;
    logic                  init_busy;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_hist, upd_taken, upd_target, upd_mispredict,
        input  pred_taken, pred_pc, pred_hist, init_busy
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_hist, upd_taken, upd_target, upd_mispredict,
        output pred_taken, pred_pc, pred_hist, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/btb_predictor_param_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Combinational saturating increment/decrement of a
//               CTR_BITS direction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  wire logic [CTR_BITS-1:0] i_ctr,
    input  wire logic                i_up,
    output logic      [CTR_BITS-1:0] o_ctr
);
    localparam logic [CTR_BITS-1:0] c_max = '1;
    localparam logic [CTR_BITS-1:0] c_min = '0;
    localparam logic [CTR_BITS-1:0] c_one = CTR_BITS'(1);

    // Step toward the resolved direction, holding at either rail.
    always_comb begin
        o_ctr = i_ctr;
        if (i_up) begin
            if (i_ctr != c_max) o_ctr = i_ctr + c_one;
        end else begin
            if (i_ctr != c_min) o_ctr = i_ctr - c_one;
        end
    end
endmodule
`default_nettype wire

// File: rtl/btb_predictor_param.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor_param
// Description : Direct-mapped tagged BTB with saturating direction counters,
//               post-reset clear sweep and tag-miss allocation. Lookup is
//               combinational; updates land at the clock edge with no bypass.
//               Optional feature macro: BP_GSHARE_EN (gshare index using a
//               non-speculative global history register).
// Revision    : 1.0 - initial release
// ============================================================================
module btb_predictor_param
    import bp_pkg::*;
#(
    parameter int WORD_SIZE  = BP_WORD_SIZE,
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    btb_predictor_param_if.slave bp
);
    localparam int                    c_entries     = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] c_last_idx    = '1;
    localparam logic [CTR_BITS-1:0]   c_ctr_weak_nt = CTR_BITS'(CTR_WEAK_NT(CTR_BITS));
    localparam logic [CTR_BITS-1:0]   c_ctr_weak_t  = CTR_BITS'(CTR_WEAK_T(CTR_BITS));

    // Table storage, one element per field.
    logic                  r_valid  [c_entries];
    logic [TAG_BITS-1:0]   r_tag    [c_entries];
    logic [WORD_SIZE-1:0]  r_target [c_entries];
    logic [CTR_BITS-1:0]   r_ctr    [c_entries];

    bp_state_t             r_state;
    bp_state_t             w_state_next;
    logic [INDEX_BITS-1:0] r_ptr;
    logic                  w_ready;

    logic [INDEX_BITS-1:0] w_hist;
    logic [INDEX_BITS-1:0] w_upd_hist;

    logic [INDEX_BITS-1:0] w_fetch_idx;
    logic [TAG_BITS-1:0]   w_fetch_tag;
    logic                  w_fetch_hit;
    logic                  w_pred_taken;

    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic                  w_upd_hit;
    logic [CTR_BITS-1:0]   w_ctr_next;

    logic                  w_unused_ok;

    assign w_ready = (r_state == BP_READY);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= BP_INIT;
        else       r_state <= w_state_next;
    end

    // Leave INIT once the sweep has written the last index.
    always_comb begin
        w_state_next = r_state;
        if (r_state == BP_INIT && r_ptr == c_last_idx) w_state_next = BP_READY;
    end

    // Sweep pointer advances only while clearing; its wrap coincides with READY.
    always_ff @(posedge clk) begin
        if (reset)                  r_ptr <= '0;
        else if (r_state == BP_INIT) r_ptr <= r_ptr + INDEX_BITS'(1);
    end

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] r_ghr;
    logic [INDEX_BITS-1:0] w_ghr_next;

    // Shift the resolved direction into the history carried with the branch;
    // a mispredict repairs to this same value since history is non-speculative.
    always_comb begin
        w_ghr_next = INDEX_BITS'({bp.upd_hist, bp.upd_taken});
    end

    // Global history register, advanced only by resolved branches in READY.
    always_ff @(posedge clk) begin
        if (reset)                           r_ghr <= '0;
        else if (w_ready && bp.upd_valid)    r_ghr <= w_ghr_next;
    end

    assign w_hist     = r_ghr;
    assign w_upd_hist = bp.upd_hist;
`else
    assign w_hist     = '0;
    assign w_upd_hist = '0;
`endif

    // Combinational lookup; INIT forces a miss so the table contents are irrelevant.
    assign w_fetch_idx  = bp.fetch_pc[INDEX_BITS-1:0] ^ w_hist;
    assign w_fetch_tag  = bp.fetch_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
    assign w_fetch_hit  = w_ready && r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign w_pred_taken = w_fetch_hit && r_ctr[w_fetch_idx][CTR_BITS-1];

    assign bp.pred_taken = w_pred_taken;
    assign bp.pred_pc    = w_pred_taken ? r_target[w_fetch_idx] : bp.fetch_pc + WORD_SIZE'(1);
    assign bp.pred_hist  = w_hist;
    assign bp.init_busy  = ~w_ready;

    // Update-side index/tag use the history snapshot that travelled with the branch.
    assign w_upd_idx = bp.upd_pc[INDEX_BITS-1:0] ^ w_upd_hist;
    assign w_upd_tag = bp.upd_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .i_ctr (r_ctr[w_upd_idx]),
        .i_up  (bp.upd_taken),
        .o_ctr (w_ctr_next)
    );

    // Table writes: clear sweep in INIT, train/allocate in READY; updates in INIT are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == BP_INIT) begin
                r_valid[r_ptr]  <= 1'b0;
                r_tag[r_ptr]    <= '0;
                r_target[r_ptr] <= '0;
                r_ctr[r_ptr]    <= c_ctr_weak_nt;
            end else if (bp.upd_valid) begin
                if (w_upd_hit) begin
                    r_ctr[w_upd_idx] <= w_ctr_next;
                    if (bp.upd_taken) r_target[w_upd_idx] <= bp.upd_target;
                end else if (bp.upd_taken) begin
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_target[w_upd_idx] <= bp.upd_target;
                    r_ctr[w_upd_idx]    <= c_ctr_weak_t;
                end
            end
        end
    end

    // Bits that are deliberately unused in some configurations.
    assign w_unused_ok = ^{bp.upd_mispredict, bp.upd_hist, bp.fetch_pc, bp.upd_pc};

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_predictor_param
// Description : Self-checking bench for btb_predictor_param against a
//               table-level reference model (honours BP_GSHARE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_predictor_param;
    import bp_pkg::*;

    localparam int WS = 16;
    localparam int IB = 8;
    localparam int TB = 8;
    localparam int CB = 2;
    localparam int N  = 1 << IB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    btb_predictor_param_if #(.WORD_SIZE(WS), .INDEX_BITS(IB)) bp ();

    btb_predictor_param #(
        .WORD_SIZE (WS),
        .INDEX_BITS(IB),
        .TAG_BITS  (TB),
        .CTR_BITS  (CB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bp)
    );

    // Reference model: the table as plain arrays.
    bit m_valid  [N];
    int m_tag    [N];
    int m_target [N];
    int m_ctr    [N];
    bit m_ready;
    int m_sweep;
    int m_ghr;

    int checks = 0;
    int errors = 0;

    function automatic void model_pred(input int pc, output bit t, output int npc, output int h);
        int i;
        i   = (pc ^ m_ghr) & (N - 1);
        h   = m_ghr;
        t   = m_ready && m_valid[i] && (m_tag[i] == ((pc >> IB) & ((1 << TB) - 1)))
              && (m_ctr[i] >= (1 << (CB - 1)));
        npc = t ? m_target[i] : ((pc + 1) & ((1 << WS) - 1));
    endfunction

    // Apply what the coming clock edge does, given the inputs now driven.
    function automatic void model_edge();
        int hist, i, tag;
        if (reset) begin
            m_ready = 0; m_sweep = 0; m_ghr = 0;
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = (1 << (CB - 1)) - 1;
            end
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == N) m_ready = 1;
        end else if (bp.upd_valid) begin
`ifdef BP_GSHARE_EN
            hist = int'(bp.upd_hist);
`else
            hist = 0;
`endif
            i   = (int'(bp.upd_pc) ^ hist) & (N - 1);
            tag = (int'(bp.upd_pc) >> IB) & ((1 << TB) - 1);
            if (m_valid[i] && m_tag[i] == tag) begin
                if (bp.upd_taken) begin
                    if (m_ctr[i] < (1 << CB) - 1) m_ctr[i]++;
                    m_target[i] = int'(bp.upd_target);
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i]--;
                end
            end else if (bp.upd_taken) begin
                m_valid[i] = 1; m_tag[i] = tag; m_target[i] = int'(bp.upd_target);
                m_ctr[i] = 1 << (CB - 1);
            end
`ifdef BP_GSHARE_EN
            m_ghr = ((hist << 1) | int'(bp.upd_taken)) & (N - 1);
`endif
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input int pc, input bit taken, input int target);
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = WS'(pc);
        bp.upd_taken      = taken;
        bp.upd_target     = WS'(target);
        bp.upd_hist       = IB'(m_ghr);
        bp.upd_mispredict = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_and_wait(output int busy);
        reset = 1'b1; bp.upd_valid = 1'b0; step(); reset = 1'b0;
        busy = 0;
        while (bp.init_busy === 1'b1 && busy < 1000) begin step(); busy++; end
    endtask

    task automatic test_reset();
        int busy;
        reset = 1'b1; bp.upd_valid = 1'b0; bp.fetch_pc = 16'h0040;
        step(); reset = 1'b0; #1;
        busy = 0;
        while (bp.init_busy === 1'b1 && busy < 1000) begin
            checks++;
            if ({bp.pred_taken, bp.pred_pc, bp.pred_hist} !== {1'b0, 16'h0041, 8'h00}) begin
                errors++;
                $display("FAIL init_pred got taken=%0b pc=%h hist=%h want taken=0 pc=0041 hist=00",
                         bp.pred_taken, bp.pred_pc, bp.pred_hist);
            end
            step(); busy++;
        end
        checks++;
        if (busy !== N) begin errors++; $display("FAIL init_busy_len got %0d want %0d", busy, N); end
    endtask

    task automatic test_alloc();
        bit t; int p, h;
        bp.fetch_pc = 16'h0040;
        drive_upd(16'h0040, 1'b1, 16'h0050);
        #1; model_pred(32'h40, t, p, h);
        checks++;
        if ({bp.pred_taken, bp.pred_pc} !== {t, p[15:0]}) begin
            errors++; $display("FAIL alloc_same_cycle got %0b/%h want %0b/%h", bp.pred_taken, bp.pred_pc, t, p[15:0]);
        end
        step(); bp.upd_valid = 1'b0; #1;
        model_pred(32'h40, t, p, h);
        checks++;
        if ({bp.pred_taken, bp.pred_pc, bp.pred_hist} !== {t, p[15:0], h[7:0]}) begin
            errors++; $display("FAIL alloc_hit got %0b/%h/%h want %0b/%h/%h",
                               bp.pred_taken, bp.pred_pc, bp.pred_hist, t, p[15:0], h[7:0]);
        end
`ifndef BP_GSHARE_EN
        checks++;
        if ({bp.pred_taken, bp.pred_pc} !== {1'b1, 16'h0050}) begin
            errors++; $display("FAIL alloc_const got %0b/%h want 1/0050", bp.pred_taken, bp.pred_pc);
        end
`endif
    endtask

    task automatic test_counter();
        bit t; int p, h;
        bit dirs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bp.fetch_pc = 16'h0040;
        for (int k = 0; k < 4; k++) begin
            drive_upd(16'h0040, dirs[k], 16'h0060);
            step(); bp.upd_valid = 1'b0; #1;
            model_pred(32'h40, t, p, h);
            checks++;
            if ({bp.pred_taken, bp.pred_pc} !== {t, p[15:0]}) begin
                errors++; $display("FAIL counter_step%0d got %0b/%h want %0b/%h", k, bp.pred_taken, bp.pred_pc, t, p[15:0]);
            end
        end
    endtask

    task automatic test_alias();
        bit t; int p, h;
        drive_upd(16'h0040, 1'b1, 16'h0050);
        step();
        drive_upd(16'h0040, 1'b1, 16'h0050);
        step(); bp.upd_valid = 1'b0;
        bp.fetch_pc = 16'h0140; #1;
        model_pred(32'h140, t, p, h);
        checks++;
        if ({bp.pred_taken, bp.pred_pc} !== {t, p[15:0]}) begin
            errors++; $display("FAIL alias_miss got %0b/%h want %0b/%h", bp.pred_taken, bp.pred_pc, t, p[15:0]);
        end
        drive_upd(16'h0140, 1'b0, 16'h0000);
        step(); bp.upd_valid = 1'b0;
        bp.fetch_pc = 16'h0040; #1;
        model_pred(32'h40, t, p, h);
        checks++;
        if ({bp.pred_taken, bp.pred_pc} !== {t, p[15:0]}) begin
            errors++; $display("FAIL alias_intact got %0b/%h want %0b/%h", bp.pred_taken, bp.pred_pc, t, p[15:0]);
        end
    endtask

    task automatic test_midsweep();
        bit t; int p, h, busy;
        reset = 1'b1; bp.upd_valid = 1'b0; step(); reset = 1'b0;
        for (int k = 0; k < 100; k++) step();
        reset = 1'b1; step(); reset = 1'b0;
        busy = 0;
        while (bp.init_busy === 1'b1 && busy < 1000) begin
            drive_upd(16'h0040, 1'b1, 16'h0077);
            step(); busy++;
        end
        bp.upd_valid = 1'b0;
        checks++;
        if (busy !== N) begin errors++; $display("FAIL midsweep_len got %0d want %0d", busy, N); end
        bp.fetch_pc = 16'h0040; #1;
        model_pred(32'h40, t, p, h);
        checks++;
        if ({bp.pred_taken, bp.pred_pc, bp.pred_hist} !== {t, p[15:0], h[7:0]}) begin
            errors++; $display("FAIL midsweep_drop got %0b/%h/%h want %0b/%h/%h",
                               bp.pred_taken, bp.pred_pc, bp.pred_hist, t, p[15:0], h[7:0]);
        end
    endtask

    task automatic test_gshare();
        int busy;
        int pcs [3] = '{32'h0047, 32'h0010, 32'h0010};
        reset_and_wait(busy);
        checks++;
        if (busy !== N) begin errors++; $display("FAIL gshare_sweep got %0d want %0d", busy, N); end
        for (int k = 0; k < 3; k++) begin
            drive_upd(pcs[k], 1'b1, 16'h1234);
            step();
        end
        bp.upd_valid = 1'b0; bp.fetch_pc = 16'h0040; #1;
        checks++;
`ifdef BP_GSHARE_EN
        if ({bp.pred_hist, bp.pred_taken, bp.pred_pc} !== {8'h07, 1'b1, 16'h1234}) begin
            errors++; $display("FAIL gshare_idx got hist=%h %0b/%h want hist=07 1/1234", bp.pred_hist, bp.pred_taken, bp.pred_pc);
        end
`else
        if ({bp.pred_hist, bp.pred_taken, bp.pred_pc} !== {8'h00, 1'b0, 16'h0041}) begin
            errors++; $display("FAIL nogshare_idx got hist=%h %0b/%h want hist=00 0/0041", bp.pred_hist, bp.pred_taken, bp.pred_pc);
        end
`endif
    endtask

    task automatic test_random();
        bit t; int p, h, pc;
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 999) == 0);
            pc = ($urandom_range(0, 3) << IB) | $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) pc = $urandom_range(0, 16'hffff);
            bp.fetch_pc = WS'(pc);
            if ($urandom_range(0, 1) == 1) begin
                drive_upd(($urandom_range(0, 3) << IB) | $urandom_range(0, 15),
                          1'($urandom_range(0, 1)), $urandom_range(0, 16'hffff));
                if ($urandom_range(0, 3) == 0) bp.upd_hist = IB'($urandom_range(0, N - 1));
            end else begin
                bp.upd_valid = 1'b0;
            end
            #1;
            model_pred(pc, t, p, h);
            checks++;
            if ({bp.init_busy, bp.pred_taken, bp.pred_pc, bp.pred_hist} !== {~m_ready, t, p[15:0], h[7:0]}) begin
                errors++;
                $display("FAIL random_c%0d pc=%h got busy=%0b %0b/%h/%h want busy=%0b %0b/%h/%h", k, pc[15:0],
                         bp.init_busy, bp.pred_taken, bp.pred_pc, bp.pred_hist, ~m_ready, t, p[15:0], h[7:0]);
            end
            step();
        end
        reset = 1'b0; bp.upd_valid = 1'b0;
    endtask

    initial begin
        bp.fetch_pc = '0; bp.upd_valid = 1'b0; bp.upd_pc = '0; bp.upd_hist = '0;
        bp.upd_taken = 1'b0; bp.upd_target = '0; bp.upd_mispredict = 1'b0;
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_midsweep();
        test_gshare();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btb_predictor_param.md
# btb_predictor_param

Parametrised branch-target predictor for the 5-stage pipeline's IF stage: a direct-mapped tagged BTB with per-entry valid bit and N-bit saturating direction counters. It replaces the fixed 256-entry/8-bit-tag predictor. It adds a post-reset table-clear sweep, tag-miss allocation, and an optional gshare global-history index. The ID-stage branch resolver drives the update port.

## Interface
- `WORD_SIZE`, 16, PC/target width.
- `INDEX_BITS`, 8, table index width; the table holds 2^INDEX_BITS entries.
- `TAG_BITS`, 8, stored tag width. Must satisfy INDEX_BITS + TAG_BITS <= WORD_SIZE.
- `CTR_BITS`, 2, direction counter width (>= 1).
- Clock and reset (already decided): one clock `clk`; reset `reset` is synchronous and active-high.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `fetch_pc` input WORD_SIZE: PC being fetched.
- `pred_taken` output 1: predicted taken.
- `pred_pc` output WORD_SIZE: predicted next PC.
- `pred_hist` output INDEX_BITS: history snapshot used for this lookup. It is all zeros without gshare.
- `upd_valid` input 1: resolved branch this cycle.
- `upd_pc` input WORD_SIZE: PC of the resolved branch.
- `upd_hist` input INDEX_BITS: the `pred_hist` value carried down the pipe with that branch.
- `upd_taken` input 1: actual direction.
- `upd_target` input WORD_SIZE: taken target (PC + 1 + imm).
- `upd_mispredict` input 1: the prediction was wrong.
- `init_busy` output 1: clear sweep in progress.

## Operation
- Entry fields: valid, tag[TAG_BITS], target[WORD_SIZE], ctr[CTR_BITS].
- Index and tag:
  - idx = pc[INDEX_BITS-1:0], XORed with history when gshare is enabled.
  - tag = pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS].
- Lookup is combinational.
  - Hit = ready && valid && tag match.
  - `pred_taken` = hit && ctr MSB.
  - `pred_pc` = pred_taken ? target : fetch_pc + 1. Addition wraps modulo 2^WORD_SIZE.
- FSM states:
  - INIT: a sweep pointer writes entry[ptr] = {valid 0, tag 0, target 0, ctr = 2^(CTR_BITS-1)-1 (weakly not-taken)}, one entry per cycle, `init_busy`=1. When the last index is written, go to READY.
  - READY: normal operation.
- Update (READY && upd_valid), applied at the clock edge, to entry[idx(upd_pc, upd_hist)]:
  - Tag match and valid: ctr saturates up if taken (stops at 2^CTR_BITS-1), down if not taken (stops at 0). Target is written only when taken.
  - Miss and taken: allocate. Write tag and target, set valid=1, ctr = 2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no write.
- Updates in INIT are dropped. The bench must see no table change.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no bypass.

## Timing
- Prediction has zero latency (combinational from `fetch_pc`). An update is visible to lookups in the cycle after its edge.
- On reset: FSM=INIT, ptr=0, history=0. While in INIT, `init_busy`=1, `pred_taken`=0, `pred_pc`=fetch_pc+1, and `pred_hist`=0.
- The sweep takes exactly 2^INDEX_BITS cycles. `init_busy` falls in the cycle after ptr reaches 2^INDEX_BITS-1.
- Reset asserted mid-sweep or in READY restarts the sweep at ptr=0.
- Pointer wrap ends the sweep. It never wraps back to 0 in READY.

## Configuration
- `BP_GSHARE_EN` defined:
  - An INDEX_BITS global history register (GHR) is compiled in. Lookup index = fetch_pc idx XOR GHR, and `pred_hist`=GHR.
  - Speculative shift: on each cycle with READY && pred_taken-or-not for a fetched branch? No. The GHR is non-speculative: on upd_valid in READY, GHR <= {upd_hist[INDEX_BITS-2:0], upd_taken}.
  - `upd_mispredict` forces the same repair value. It is equal to the normal update here; the port is kept so speculative history can be added later.
  - Reset clears the GHR.
- Not defined: there is no GHR, the history term is 0, `pred_hist`=0, and `upd_hist`/`upd_mispredict` are ignored.

## Structure
- Package `bp_pkg`: WORD_SIZE default, FSM state enum {BP_INIT, BP_READY}, and counter encoding constants CTR_WEAK_NT/CTR_WEAK_T expressed as functions of CTR_BITS.
- One sub-module `sat_counter`: a CTR_BITS combinational saturating increment/decrement, instantiated on the update path.

## Test plan
- Reset, then count cycles → `init_busy` high for exactly 256 cycles (defaults). During that time, fetch_pc=0x0040 gives pred_pc=0x0041 and pred_taken=0.
- Update pc=0x0040 taken, target 0x0050 → next cycle, fetch 0x0040 predicts taken to 0x0050.
- Same entry, two not-taken updates → pred_pc=0x0041; the counter reads 0 and stays at 0 after a third.
- Alias test: fetch 0x0140 (same idx, tag 0x01) after 0x0040 was allocated → miss, pred_pc=0x0141. A not-taken update at 0x0140 leaves the 0x0040 entry intact.
- Reset asserted at sweep cycle 100 → `init_busy` stays high for a further 256 cycles. An update at 0x0040 issued during the sweep has no effect.
- With `BP_GSHARE_EN`: three taken updates → GHR=0x07. Fetch 0x0040 reports pred_hist=0x07 and looks up idx 0x47.
